// File: rtl/axi_ram_rd_responder.sv
// AXI4 read-channel responder backed by a byte-writable on-chip RAM with a backdoor load port.
// Define AXI_RAM_RD_OUTPUT_REG_EN to add a second R output register stage after the RAM read.
module axi_ram_rd_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [ID_WIDTH-1:0]                       s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]                     s_axi_araddr,
  input  logic [7:0]                                s_axi_arlen,
  input  logic [2:0]                                s_axi_arsize,
  input  logic [1:0]                                s_axi_arburst,
  input  logic                                      s_axi_arvalid,
  output logic                                      s_axi_arready,
  output logic [ID_WIDTH-1:0]                       s_axi_rid,
  output logic [DATA_WIDTH-1:0]                     s_axi_rdata,
  output logic [1:0]                                s_axi_rresp,
  output logic                                      s_axi_rlast,
  output logic                                      s_axi_rvalid,
  input  logic                                      s_axi_rready,
  input  logic                                      ram_wr_en,
  input  logic [ADDR_WIDTH-$clog2(STRB_WIDTH)-1:0]  ram_wr_addr,
  input  logic [DATA_WIDTH-1:0]                     ram_wr_data,
  input  logic [STRB_WIDTH-1:0]                     ram_wr_strb
);

  // state   | meaning
  // IDLE    | arready high, waiting for an AR; the first beat may issue in the handshake cycle
  // BURST   | remaining beats issue whenever the output slot is free
  typedef enum logic [0:0] {ST_IDLE, ST_BURST} state_t;

  localparam int         WORD_LSB = $clog2(STRB_WIDTH);
  localparam int         WORD_AW  = ADDR_WIDTH - WORD_LSB;
  localparam int         DEPTH    = 1 << WORD_AW;
  localparam logic [2:0] MAX_SIZE = 3'(WORD_LSB);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  state_t                r_state;
  logic                  r_arready;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_count;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_err;

  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [1:0]            r_rresp;
  logic                  r_rlast;

  logic                  w_ar_hs;
  logic                  w_slot_free;
  logic                  w_issue;
  logic [ID_WIDTH-1:0]   w_cur_id;
  logic [ADDR_WIDTH-1:0] w_cur_addr;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [7:0]            w_cur_count;
  logic [7:0]            w_cur_len;
  logic [2:0]            w_cur_size;
  logic [1:0]            w_cur_burst;
  logic                  w_cur_err;
  logic                  w_cur_last;
  logic [1:0]            w_cur_resp;
  logic [DATA_WIDTH-1:0] w_rd_data;

  function automatic logic f_burst_err(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [7:0]            len,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    logic [ADDR_WIDTH-1:0] align_mask;
    logic                  wrap_len_ok;
    align_mask  = ~({ADDR_WIDTH{1'b1}} << size);
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    f_burst_err = (size > MAX_SIZE) || (burst == 2'b11) ||
                  ((burst == 2'b10) && !wrap_len_ok) ||
                  ((burst == 2'b10) && ((addr & align_mask) != '0));
  endfunction

  // Reserved burst type advances like INCR; its beats are flagged SLVERR anyway.
  function automatic logic [ADDR_WIDTH-1:0] f_next_addr(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [7:0]            len,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] span;
    logic [ADDR_WIDTH-1:0] mask;
    logic [ADDR_WIDTH-1:0] inc;
    step = ADDR_WIDTH'(1) << size;
    span = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
    mask = span - ADDR_WIDTH'(1);
    inc  = addr + step;
    case (burst)
      2'b00:   f_next_addr = addr;
      2'b10:   f_next_addr = (addr & ~mask) | (inc & mask);
      default: f_next_addr = inc;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (ram_wr_en) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (ram_wr_strb[b]) r_mem[ram_wr_addr][b*8 +: 8] <= ram_wr_data[b*8 +: 8];
      end
    end
  end

  // In IDLE the beat source is the AR channel itself so the first beat can issue on the handshake.
  always_comb begin
    w_cur_id    = r_id;
    w_cur_addr  = r_addr;
    w_cur_count = r_count;
    w_cur_len   = r_len;
    w_cur_size  = r_size;
    w_cur_burst = r_burst;
    w_cur_err   = r_err;
    if (r_state == ST_IDLE) begin
      w_cur_id    = s_axi_arid;
      w_cur_addr  = s_axi_araddr;
      w_cur_count = s_axi_arlen;
      w_cur_len   = s_axi_arlen;
      w_cur_size  = s_axi_arsize;
      w_cur_burst = s_axi_arburst;
      w_cur_err   = f_burst_err(s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst);
    end
  end

  assign w_ar_hs     = s_axi_arvalid && r_arready;
  assign w_issue     = w_slot_free && (w_ar_hs || (r_state == ST_BURST));
  assign w_cur_last  = (w_cur_count == 8'd0);
  assign w_cur_resp  = w_cur_err ? 2'b10 : 2'b00;
  assign w_next_addr = f_next_addr(w_cur_addr, w_cur_len, w_cur_size, w_cur_burst);
  assign w_rd_data   = r_mem[w_cur_addr[ADDR_WIDTH-1:WORD_LSB]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_arready <= 1'b0;
      r_id      <= '0;
      r_addr    <= '0;
      r_count   <= '0;
      r_len     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_id    <= s_axi_arid;
        r_addr  <= s_axi_araddr;
        r_count <= s_axi_arlen;
        r_len   <= s_axi_arlen;
        r_size  <= s_axi_arsize;
        r_burst <= s_axi_arburst;
        r_err   <= w_cur_err;
      end
      if (w_issue) begin
        r_addr  <= w_next_addr;
        r_count <= w_cur_count - 8'd1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_ar_hs && !(w_issue && w_cur_last)) begin
            r_state   <= ST_BURST;
            r_arready <= 1'b0;
          end else begin
            r_arready <= 1'b1;
          end
        end
        ST_BURST: begin
          if (w_issue && w_cur_last) begin
            r_state   <= ST_IDLE;
            r_arready <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_arready <= 1'b0;
        end
      endcase
    end
  end

`ifdef AXI_RAM_RD_OUTPUT_REG_EN
  logic                  r_s1_valid;
  logic [DATA_WIDTH-1:0] r_s1_data;
  logic [ID_WIDTH-1:0]   r_s1_id;
  logic [1:0]            r_s1_resp;
  logic                  r_s1_last;
  logic                  w_s2_free;

  assign w_s2_free   = !r_rvalid || s_axi_rready;
  assign w_slot_free = !r_s1_valid || w_s2_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_id    <= '0;
      r_s1_resp  <= '0;
      r_s1_last  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rid      <= '0;
      r_rresp    <= '0;
      r_rlast    <= 1'b0;
    end else begin
      if (w_issue) begin
        r_s1_valid <= 1'b1;
        r_s1_data  <= w_rd_data;
        r_s1_id    <= w_cur_id;
        r_s1_resp  <= w_cur_resp;
        r_s1_last  <= w_cur_last;
      end else if (w_s2_free) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s2_free) begin
        r_rvalid <= r_s1_valid;
        if (r_s1_valid) begin
          r_rdata <= r_s1_data;
          r_rid   <= r_s1_id;
          r_rresp <= r_s1_resp;
          r_rlast <= r_s1_last;
        end else begin
          r_rlast <= 1'b0;
        end
      end
    end
  end
`else
  assign w_slot_free = !r_rvalid || s_axi_rready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rid    <= '0;
      r_rresp  <= '0;
      r_rlast  <= 1'b0;
    end else if (w_issue) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
      r_rid    <= w_cur_id;
      r_rresp  <= w_cur_resp;
      r_rlast  <= w_cur_last;
    end else if (s_axi_rready) begin
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
    end
  end
`endif

  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rid     = r_rid;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rlast   = r_rlast;

endmodule

// File: tb/tb_axi_ram_rd_responder.sv
// Bench for axi_ram_rd_responder: directed and random bursts checked against an address-arithmetic
// reference model with an expected-beat queue.
module tb_axi_ram_rd_responder;

`ifdef AXI_RAM_RD_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_axi_arid;
  logic [15:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [7:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic        ram_wr_en;
  logic [13:0] ram_wr_addr;
  logic [31:0] ram_wr_data;
  logic [3:0]  ram_wr_strb;

  always #5 clk = ~clk;

  axi_ram_rd_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4), .ID_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready), .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data), .ram_wr_strb(ram_wr_strb)
  );

  typedef struct {
    logic [31:0] data;
    logic [7:0]  id;
    logic [1:0]  resp;
    logic        last;
    logic        chk_data;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] mdl_mem [0:16383];
  int          tests = 0;
  int          fails = 0;
  int          bubbles = 0;
  int          beats_seen = 0;
  int          rr_mode = 0;
  logic        stalled = 1'b0;
  logic        hs_flag = 1'b0;
  logic [31:0] hold_data;
  logic [10:0] hold_ctl;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Beat addresses from closed-form arithmetic: start + i*step, or offset modulo span for WRAP.
  function automatic void push_burst(input logic [7:0] id, input logic [15:0] addr,
                                     input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    int    step, span, lower, a, ia, il;
    bit    len_ok, err;
    beat_t b;
    ia     = int'(addr);
    il     = int'(len);
    step   = 1 << size;
    span   = (il + 1) * step;
    len_ok = (il == 1) || (il == 3) || (il == 7) || (il == 15);
    err    = (size > 3'd2) || (burst == 2'b11) || (burst == 2'b10 && !len_ok) ||
             (burst == 2'b10 && (ia % step) != 0);
    for (int i = 0; i <= il; i++) begin
      case (burst)
        2'b00: a = ia;
        2'b10: begin
          lower = (ia / span) * span;
          a = lower + ((ia - lower) + i * step) % span;
        end
        default: a = (ia + i * step) % 65536;
      endcase
      b.data     = mdl_mem[a / 4];
      b.id       = id;
      b.resp     = err ? 2'b10 : 2'b00;
      b.last     = (i == il);
      b.chk_data = (burst != 2'b11) && !(burst == 2'b10 && !len_ok);
      exp_q.push_back(b);
    end
  endfunction

  task automatic set_rr();
    case (rr_mode)
      0: s_axi_rready = 1'b1;
      1: s_axi_rready = ~s_axi_rready;
      default: s_axi_rready = ($urandom % 4) != 0;
    endcase
  endtask

  // Called just after a falling edge with this cycle's inputs driven; checks, then advances one clock.
  task automatic step();
    bit    ar_hs;
    beat_t b;
    if (s_axi_rvalid) begin
      if (stalled) begin
        chk("hold_data", 64'(s_axi_rdata), 64'(hold_data));
        chk("hold_ctl", 64'({s_axi_rid, s_axi_rlast, s_axi_rresp}), 64'(hold_ctl));
      end
      if (s_axi_rready && !rst) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 64'(s_axi_rvalid), 64'(0));
        end else begin
          b = exp_q.pop_front();
          if (b.chk_data) chk("rdata", 64'(s_axi_rdata), 64'(b.data));
          chk("rid", 64'(s_axi_rid), 64'(b.id));
          chk("rresp", 64'(s_axi_rresp), 64'(b.resp));
          chk("rlast", 64'(s_axi_rlast), 64'(b.last));
          beats_seen++;
        end
        stalled = 1'b0;
      end else begin
        stalled   = 1'b1;
        hold_data = s_axi_rdata;
        hold_ctl  = {s_axi_rid, s_axi_rlast, s_axi_rresp};
      end
    end else begin
      stalled = 1'b0;
      if (s_axi_rready && !rst && exp_q.size() != 0) bubbles++;
    end
    ar_hs = s_axi_arvalid && s_axi_arready && !rst;
    if (ar_hs) begin
      push_burst(s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst);
      hs_flag = 1'b1;
    end
    if (ram_wr_en) begin
      for (int k = 0; k < 4; k++)
        if (ram_wr_strb[k]) mdl_mem[ram_wr_addr][k*8 +: 8] = ram_wr_data[k*8 +: 8];
    end
    @(posedge clk);
    #1;
    if (ar_hs) s_axi_arvalid = 1'b0;
    ram_wr_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic bd_write(input logic [13:0] a, input logic [31:0] d, input logic [3:0] s);
    ram_wr_addr = a;
    ram_wr_data = d;
    ram_wr_strb = s;
    ram_wr_en   = 1'b1;
    step();
  endtask

  task automatic send_ar(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    s_axi_arid    = id;
    s_axi_araddr  = addr;
    s_axi_arlen   = len;
    s_axi_arsize  = size;
    s_axi_arburst = burst;
    s_axi_arvalid = 1'b1;
    hs_flag       = 1'b0;
    for (int n = 0; n < 60 && !hs_flag; n++) begin
      set_rr();
      step();
    end
    chk("ar_accept", 64'(hs_flag), 64'(1));
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && (exp_q.size() != 0 || s_axi_rvalid || s_axi_arvalid); n++) begin
      set_rr();
      step();
    end
    chk("drained", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           n, start;
    logic [7:0]   len;
    logic [2:0]   size;
    logic [1:0]   burst;
    logic [15:0]  addr;
    logic [7:0]   wrap_lens [4];
    wrap_lens = '{8'd1, 8'd3, 8'd7, 8'd15};

    rst = 1'b1;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
    s_axi_arburst = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    ram_wr_en = 1'b0; ram_wr_addr = '0; ram_wr_data = '0; ram_wr_strb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", 64'({s_axi_arready, s_axi_rvalid, s_axi_rlast, s_axi_rid, s_axi_rdata, s_axi_rresp}), 64'(0));
    rst = 1'b0;
    step();
    chk("arready_after_rst", 64'(s_axi_arready), 64'(1));

    for (int i = 0; i < 16; i++) bd_write(14'(i), 32'h1000 + 32'(i), 4'hF);
    bd_write(14'h3FFF, 32'hDEAD3FFF, 4'hF);

    // INCR from 0, first-beat latency and arready drop.
    rr_mode = 0;
    send_ar(8'h5A, 16'h0000, 8'd3, 3'd2, 2'b01);
    chk("arready_busy", 64'(s_axi_arready), 64'(0));
    n = 1;
    while (!s_axi_rvalid && n < 10) begin
      set_rr();
      step();
      n++;
    end
    chk("first_lat", 64'(n), 64'(LAT));
    drain();

    send_ar(8'h11, 16'h0008, 8'd3, 3'd2, 2'b10);
    drain();
    send_ar(8'h22, 16'h0010, 8'd2, 3'd2, 2'b00);
    drain();
    send_ar(8'h33, 16'hFFFC, 8'd1, 3'd2, 2'b01);
    drain();

    // Backpressure toggling.
    rr_mode = 1;
    send_ar(8'h44, 16'h0004, 8'd7, 3'd2, 2'b01);
    drain();

    // Back-to-back bursts with rready held high.
    rr_mode = 0;
    send_ar(8'h55, 16'h0000, 8'd3, 3'd2, 2'b01);
    for (int k = 0; k < 10 && !s_axi_rvalid; k++) step();
    bubbles       = 0;
    s_axi_arid    = 8'h66;
    s_axi_araddr  = 16'h0020;
    s_axi_arlen   = 8'd3;
    s_axi_arsize  = 3'd2;
    s_axi_arburst = 2'b01;
    s_axi_arvalid = 1'b1;
    drain();
    chk("b2b_bubbles", 64'(bubbles), 64'(0));

    // Error bursts.
    send_ar(8'h77, 16'h0000, 8'd3, 3'd3, 2'b01);
    drain();
    send_ar(8'h78, 16'h0004, 8'd2, 3'd2, 2'b11);
    drain();
    send_ar(8'h79, 16'h0006, 8'd3, 3'd2, 2'b10);
    drain();
    send_ar(8'h7A, 16'h0000, 8'd2, 3'd2, 2'b10);
    drain();

    // Read-first on a simultaneous backdoor write, then the new value, then a partial write.
    ram_wr_addr = 14'd5;
    ram_wr_data = 32'hBEEF0005;
    ram_wr_strb = 4'hF;
    ram_wr_en   = 1'b1;
    send_ar(8'h80, 16'h0014, 8'd0, 3'd2, 2'b00);
    drain();
    send_ar(8'h81, 16'h0014, 8'd0, 3'd2, 2'b00);
    drain();
    bd_write(14'd6, 32'hAAAA5555, 4'b0011);
    send_ar(8'h82, 16'h0018, 8'd0, 3'd2, 2'b01);
    drain();

    // Reset during a burst.
    send_ar(8'h90, 16'h0000, 8'd7, 3'd2, 2'b01);
    start = beats_seen;
    for (int k = 0; k < 20 && beats_seen < start + 2; k++) begin
      set_rr();
      step();
    end
    s_axi_rready = 1'b0;
    rst = 1'b1;
    step();
    chk("rst_mid_rvalid", 64'(s_axi_rvalid), 64'(0));
    chk("rst_mid_arready", 64'(s_axi_arready), 64'(0));
    exp_q.delete();
    rst = 1'b0;
    step();
    chk("arready_after_mid_rst", 64'(s_axi_arready), 64'(1));
    send_ar(8'h91, 16'h0020, 8'd3, 3'd2, 2'b01);
    drain();

    // Randomized bursts over a randomly loaded region.
    for (int i = 0; i < 128; i++) bd_write(14'(i), $urandom, 4'hF);
    for (int t = 0; t < 40; t++) begin
      rr_mode = (t % 5 == 0) ? 0 : 2;
      burst = 2'($urandom % 4);
      size  = 3'($urandom % 4);
      len   = 8'($urandom % 16);
      addr  = 16'($urandom_range(0, 255));
      if (burst == 2'b10 && ($urandom % 4) != 0) begin
        len  = wrap_lens[$urandom % 4];
        addr = addr & ~16'((1 << size) - 1);
      end
      send_ar(8'($urandom), addr, len, size, burst);
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_ram_rd_responder.md
Name: axi_ram_rd_responder

Overview:
AXI4 read-channel responder (slave) backed by on-chip RAM. It answers AR bursts from a read-side AXI master such as the team's DMA read engine, returning R beats at full throughput. It serves as a bench target for the DMA read engine and as a small mailbox/buffer on the interconnect. The RAM is loaded through a simple synchronous backdoor write port.

Parameters:
DATA_WIDTH, 32, AXI data width in bits (8·2^n).
ADDR_WIDTH, 16, AXI byte-address width; RAM depth = 2^ADDR_WIDTH / STRB_WIDTH words.
STRB_WIDTH, DATA_WIDTH/8, byte lanes per word.
ID_WIDTH, 8, AXI ID width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_axi_arid  in  ID_WIDTH  read ID
s_axi_araddr  in  ADDR_WIDTH  burst start byte address
s_axi_arlen  in  8  beats-1
s_axi_arsize  in  3  log2 bytes per beat
s_axi_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rid  out  ID_WIDTH  returned ID
s_axi_rdata  out  DATA_WIDTH  read data (full word; master picks lanes)
s_axi_rresp  out  2  00 OKAY, 10 SLVERR
s_axi_rlast  out  1  final beat
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready
ram_wr_en  in  1  backdoor write strobe
ram_wr_addr  in  ADDR_WIDTH-log2(STRB_WIDTH)  backdoor word address
ram_wr_data  in  DATA_WIDTH  backdoor data
ram_wr_strb  in  STRB_WIDTH  backdoor byte enables

Behaviour:
- Reset: arready=0, rvalid=0, rlast=0, rid=0, rdata=0, rresp=0, FSM=IDLE; RAM contents not reset. arready=1 in the first cycle after rst drops.
- FSM IDLE: arready=1. On arvalid&&arready, latch id, addr, len→count, size, burst; go to BURST; arready=0 next cycle.
- FSM BURST: issue a beat when (!rvalid || rready). The issue loads rdata=RAM[addr>>log2(STRB_WIDTH)], rid, rresp, rlast=(count==0) and sets rvalid=1 next cycle. Then count-=1 and the address advances. On issuing count==0, go to IDLE (arready=1 next cycle).
- rvalid/rdata/rid/rlast/rresp are held stable while rvalid&&!rready. rvalid clears after acceptance when no new beat is issued.
- Latency: AR handshake at cycle N → first rvalid at N+1. With rready held high: 1 beat/cycle, and back-to-back bursts have no bubble (next AR is accepted in the cycle the last beat is valid).
- Address update, with step = 1<<size:
  - FIXED: address held.
  - INCR: address += step, truncated to ADDR_WIDTH (wraps at top of space).
  - WRAP: span = (len+1)<<size; address = (addr & ~(span-1)) | ((addr+step) & (span-1)).
- SLVERR (all beats of the burst; data still driven from RAM; beat count unchanged):
  - size > log2(STRB_WIDTH)
  - burst==11
  - WRAP with len not in {1,3,7,15}
  - WRAP with start address not aligned to size
- Backdoor write and a simultaneous read to the same word: read returns the old data (read-first). Backdoor writes are accepted every cycle regardless of FSM state.
- rst asserted mid-burst: the burst is abandoned and all outputs return to reset values the next cycle.

Optional Feature:
AXI_RAM_RD_OUTPUT_REG_EN:
- Defined: adds a second output register stage after the RAM read (for BRAM output-register timing). First rvalid moves to N+2. Stage-1 advances when stage 2 is empty or draining. Throughput remains 1 beat/cycle with no beat lost or duplicated under backpressure; arready behaviour is unchanged.
- Undefined: single stage, latency as above.

Test Plan:
- Backdoor-load words 0..15 with value 0x1000+i; AR INCR addr 0x0, len 3, size 2, rready=1 → beats 0x1000..0x1003 on consecutive cycles, rlast on beat 4, rresp=00, rid echoed.
- WRAP addr 0x08, len 3, size 2 → data from words 2,3,0,1; rlast on beat 4.
- FIXED addr 0x10, len 2 → word 4 returned 3 times; then INCR from addr 0xFFFC, len 1 → words 0x3FFF then 0x0000 (address wraps).
- INCR len 7 with rready toggled 1/0 each cycle → 8 beats in order, no drop or duplicate, outputs stable while stalled; back-to-back second AR produces no idle cycle when rready=1.
- arsize=3 on 32-bit bus, and arburst=11 → every beat rresp=10 with correct beat count and rlast.
- Assert rst during beat 2 of a len-7 burst → rvalid=0 and arready=0 next cycle, arready=1 after rst drops, and a new burst returns correct data.
